// File: rtl/audio_sample_fifo.sv
// Single-clock PCM sample FIFO with a fill count, a low-water request to the producer,
// and sticky overflow/underflow flags for debug.
module audio_sample_fifo #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 256,
  parameter int LOW_MARK = 63
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       wrreq,
  input  logic [WIDTH-1:0]           data,
  input  logic                       rdreq,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       empty,
  output logic                       full,
  output logic                       req_o,
  output logic                       ovf,
  output logic                       unf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_req, r_ovf, r_unf;
  logic             w_wr_ok, w_rd_ok;

  // Acceptance uses the pre-edge flags; this alone resolves the
  // simultaneous empty/full cases (write wins when empty, read wins when full).
  assign empty   = (r_cnt == '0);
  assign full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_wr_ok = wrreq && !full;
  assign w_rd_ok = rdreq && !empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_req    <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) begin
        r_q      <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // Built from the pre-edge count, so it trails usedw by one cycle.
      r_req <= (r_cnt < (AW+1)'(LOW_MARK));
      if (wrreq && full)  r_ovf <= 1'b1;
      if (rdreq && empty) r_unf <= 1'b1;
    end
  end

  assign q     = r_q;
  assign usedw = r_cnt;
  assign req_o = r_req;
  assign ovf   = r_ovf;
  assign unf   = r_unf;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a vector table for the basic data path plus
// hand-written sequences for fill/drain, low-water, simultaneous traffic, wrap and reset.
module tb_audio_sample_fifo;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wrreq = 1'b0;
  logic [23:0] data = '0;
  logic        rdreq = 1'b0;
  logic [23:0] q;
  logic [8:0]  usedw;
  logic        empty, full, req_o, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  audio_sample_fifo #(.WIDTH(24), .DEPTH(256), .LOW_MARK(63)) dut (
    .clk(clk), .rst_i(rst_i), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .usedw(usedw), .empty(empty), .full(full), .req_o(req_o),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [23:0] d;
    logic [23:0] eq;
    logic [8:0]  eu;
    logic        ee;
    logic        ef;
    logic        eo;
    logic        eun;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(input logic wr, input logic rd, input logic [23:0] d);
    wrreq = wr; rdreq = rd; data = d;
    @(posedge clk); #1;
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " usedw"}, 32'(usedw), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " full"},  32'(full),  32'd0);
    chk({tag, " q"},     32'(q),     32'd0);
    chk({tag, " ovf"},   32'(ovf),   32'd0);
    chk({tag, " unf"},   32'(unf),   32'd0);
    chk({tag, " req_o"}, 32'(req_o), 32'd1);
  endtask

  initial begin
    int   exp_cnt;
    logic [23:0] mq[$];
    logic [23:0] exp_q;
    logic [23:0] nxt;
    logic        w, r;

    vt[0] = '{1'b1, 1'b0, 24'h000001, 24'h000000, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 24'h7FFFFF, 24'h000000, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 24'h800000, 24'h000000, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 9'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 24'h000000, 24'h000001, 9'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 24'h000000, 24'h7FFFFF, 9'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 24'h000000, 24'h800000, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 24'h000000, 24'hFFFFFF, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    // Simultaneous at empty: write taken, read rejected, q held, unf set.
    vt[8] = '{1'b1, 1'b1, 24'h123456, 24'hFFFFFF, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9] = '{1'b0, 1'b1, 24'h000000, 24'h123456, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset and idle
    @(posedge clk); #1;
    do_reset();
    chk_reset_state("reset");
    step(1'b0, 1'b0, 24'h0);
    chk_reset_state("idle");

    // Table-driven data path
    for (int i = 0; i < 10; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].d);
      chk($sformatf("vec%0d q", i),     32'(q),     32'(vt[i].eq));
      chk($sformatf("vec%0d usedw", i), 32'(usedw), 32'(vt[i].eu));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vt[i].ee));
      chk($sformatf("vec%0d full", i),  32'(full),  32'(vt[i].ef));
      chk($sformatf("vec%0d ovf", i),   32'(ovf),   32'(vt[i].eo));
      chk($sformatf("vec%0d unf", i),   32'(unf),   32'(vt[i].eun));
    end

    // Fill to capacity, overflow, drain, underflow
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 24'(i));
    chk("fill full", 32'(full), 32'd1);
    chk("fill usedw", 32'(usedw), 32'd256);
    chk("fill ovf clear", 32'(ovf), 32'd0);
    step(1'b1, 1'b0, 24'hDEAD00);
    chk("ovf set", 32'(ovf), 32'd1);
    chk("ovf usedw", 32'(usedw), 32'd256);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 24'h0);
      chk($sformatf("drain q%0d", i), 32'(q), 32'(i));
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain unf clear", 32'(unf), 32'd0);
    step(1'b0, 1'b1, 24'h0);
    chk("unf set", 32'(unf), 32'd1);
    chk("unf q held", 32'(q), 32'd255);
    chk("ovf sticky", 32'(ovf), 32'd1);

    // Low-water flag, lagging usedw by one cycle
    do_reset();
    for (int i = 0; i < 62; i++) step(1'b1, 1'b0, 24'(i));
    chk("low 62 req", 32'(req_o), 32'd1);
    step(1'b1, 1'b0, 24'd62);
    chk("low 63 usedw", 32'(usedw), 32'd63);
    chk("low 63 req lag", 32'(req_o), 32'd1);
    step(1'b0, 1'b0, 24'h0);
    chk("low 63 req", 32'(req_o), 32'd0);
    step(1'b0, 1'b1, 24'h0);
    chk("low read req lag", 32'(req_o), 32'd0);
    step(1'b0, 1'b0, 24'h0);
    chk("low read req", 32'(req_o), 32'd1);

    // Simultaneous traffic at usedw=5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'(100 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 24'(105 + i));
      chk($sformatf("simul q%0d", i), 32'(q), 32'(100 + i));
      chk($sformatf("simul usedw%0d", i), 32'(usedw), 32'd5);
    end

    // 600 mixed operations wrapping the pointers, against a queue model
    for (int i = 0; i < 5; i++) mq.push_back(24'(110 + i));
    exp_q = q;
    nxt = 24'h400000;
    for (int i = 0; i < 600; i++) begin
      w = (i % 3) != 2;
      r = (i % 5) >= 2;
      step(w, r, nxt);
      if (r && mq.size() > 0) exp_q = mq.pop_front();
      if (w && mq.size() < 256) begin
        mq.push_back(nxt);
        nxt = nxt + 24'd7;
      end
      if (r) chk($sformatf("wrap q op%0d", i), 32'(q), 32'(exp_q));
    end
    exp_cnt = mq.size();
    chk("wrap usedw", 32'(usedw), 32'(exp_cnt));

    // Reset mid-operation with 100 stored and a sticky flag set
    do_reset();
    step(1'b0, 1'b1, 24'h0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 24'(i + 1));
    chk("pre-rst usedw", 32'(usedw), 32'd100);
    chk("pre-rst unf", 32'(unf), 32'd1);
    do_reset();
    chk_reset_state("midrst");
    step(1'b1, 1'b0, 24'hABCDEF);
    step(1'b0, 1'b1, 24'h0);
    chk("post-rst q", 32'(q), 32'hABCDEF);
    chk("post-rst empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
